// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, issues credit-limited word fetches,
// buffers returned words and hands {instruction, pc} to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  logic [31:0]   pc_q;
  logic          run_q;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q;
  logic [CW-1:0] cnt_q;
  ent_t          ibuf_q [DEPTH];
  logic [PW-1:0] bh_q, bt_q;
  logic [31:0]   pcq_q [DEPTH];
  logic [PW-1:0] qh_q, qt_q;

  logic          pop, fire, rsp, keep;
  logic [CW:0]   used;
  logic          unused_lo;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign unused_lo = ^redirect_pc[1:0];

  assign id_valid = (cnt_q != '0) & ~redirect_valid;
  assign id_instruction = (cnt_q != '0) ?
                          ibuf_q[bh_q].instr :
                          32'h0000_0013;
  assign id_pc = ibuf_q[bh_q].pc;

  assign pop  = id_valid & id_ready;
  assign used = {1'b0, out_q} + {1'b0, cnt_q}
              - (CW+1)'(pop);

  // run_q keeps requests off until the first edge after reset release
  assign imem_req_valid = run_q & (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign fire = imem_req_valid & imem_req_ready;

  // responses with nothing outstanding are ignored
  assign rsp  = imem_rsp_valid & (out_q != '0);
  assign keep = rsp & (drop_q == '0) & ~redirect_valid;

  assign out_d = out_q + CW'(fire) - CW'(rsp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      run_q  <= 1'b0;
      out_q  <= '0;
      drop_q <= '0;
      cnt_q  <= '0;
      bh_q   <= '0;
      bt_q   <= '0;
      qh_q   <= '0;
      qt_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ibuf_q[i] <= '0;
        pcq_q[i]  <= '0;
      end
    end else begin
      run_q <= 1'b1;
      out_q <= out_d;
      if (redirect_valid) begin
        pc_q   <= {redirect_pc[31:2], 2'b00};
        cnt_q  <= '0;
        bh_q   <= '0;
        bt_q   <= '0;
        qh_q   <= '0;
        qt_q   <= '0;
        drop_q <= out_d;
      end else begin
        // stale fetches never enter the pc queue
        if (fire) begin
          pc_q        <= pc_q + 32'd4;
          pcq_q[qt_q] <= pc_q;
          qt_q        <= inc(qt_q);
        end
        if (rsp && drop_q != '0) begin
          drop_q <= drop_q - 1'b1;
        end
        if (keep) begin
          ibuf_q[bt_q] <= '{imem_rsp_data, pcq_q[qh_q]};
          bt_q         <= inc(bt_q);
          qh_q         <= inc(qh_q);
        end
        if (pop) begin
          bh_q <= inc(bh_q);
        end
        cnt_q <= cnt_q + CW'(keep) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed cycle table for fetch_stage with an echo memory model
// (response data = request address) of programmable availability.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instruction (id_instruction),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        idr;
    logic        men;
    logic        rd;
    logic [31:0] rpc;
    logic        erv;
    logic [31:0] ead;
    logic        eiv;
    logic [31:0] epc;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] mq[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic rdy, input logic idr,
                     input logic men, input logic rd,
                     input logic [31:0] rpc,
                     input logic erv, input logic [31:0] ead,
                     input logic eiv, input logic [31:0] epc);
    vec_t v;
    v.rdy = rdy; v.idr = idr; v.men = men; v.rd = rd;
    v.rpc = rpc; v.erv = erv; v.ead = ead;
    v.eiv = eiv; v.epc = epc;
    tv.push_back(v);
  endtask

  // called at a negedge: drive, sample, advance to next negedge
  task automatic step(input vec_t v, input int i);
    imem_req_ready = v.rdy;
    id_ready       = v.idr;
    redirect_valid = v.rd;
    redirect_pc    = v.rpc;
    if (v.men && mq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq.pop_front();
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    chk($sformatf("c%0d req_valid", i), 32'(imem_req_valid), 32'(v.erv));
    chk($sformatf("c%0d req_addr", i), imem_req_addr, v.ead);
    chk($sformatf("c%0d id_valid", i), 32'(id_valid), 32'(v.eiv));
    if (v.eiv) begin
      chk($sformatf("c%0d id_pc", i), id_pc, v.epc);
      chk($sformatf("c%0d id_instr", i), id_instruction, v.epc);
    end
    if (imem_req_valid && imem_req_ready)
      mq.push_back(imem_req_addr);
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, " id_valid"}, 32'(id_valid), 32'd0);
    chk({tag, " id_instr"}, id_instruction, 32'h0000_0013);
    chk({tag, " id_pc"}, id_pc, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;

    // rdy idr men rd rpc | rv addr iv pc
    add(1,1,1,0,0,            0,32'h0,  0,0);
    add(1,1,1,0,0,            1,32'h0,  0,0);
    add(1,1,1,0,0,            1,32'h4,  0,0);
    add(1,1,1,0,0,            1,32'h8,  1,32'h0);
    add(1,1,1,0,0,            1,32'hC,  1,32'h4);
    add(1,1,1,0,0,            1,32'h10, 1,32'h8);
    for (int k = 0; k < 5; k++)
      add(1,0,1,0,0,          0,32'h14, 1,32'hC);
    add(1,1,1,0,0,            1,32'h14, 1,32'hC);
    add(1,1,1,0,0,            1,32'h18, 1,32'h10);
    add(1,1,1,0,0,            1,32'h1C, 1,32'h14);
    add(1,1,0,0,0,            1,32'h20, 1,32'h18);
    add(1,1,0,1,32'h100,      0,32'h24, 0,0);
    add(1,1,1,0,0,            0,32'h100,0,0);
    add(1,1,1,0,0,            1,32'h100,0,0);
    add(1,1,1,0,0,            1,32'h104,0,0);
    add(1,1,1,0,0,            1,32'h108,1,32'h100);
    add(0,1,1,0,0,            1,32'h10C,1,32'h104);
    add(1,1,1,0,0,            1,32'h10C,1,32'h108);
    add(1,1,1,1,32'h200,      1,32'h110,0,0);
    add(1,1,1,0,0,            1,32'h200,0,0);
    add(1,1,1,0,0,            1,32'h204,0,0);
    add(1,1,1,0,0,            1,32'h208,1,32'h200);
    add(1,1,1,1,32'h123,      0,32'h20C,0,0);
    add(1,1,1,0,0,            1,32'h120,0,0);
    add(1,1,1,0,0,            1,32'h124,0,0);
    add(1,1,1,0,0,            1,32'h128,1,32'h120);
    add(1,1,1,1,32'hFFFF_FFFC,0,32'h12C,0,0);
    add(1,1,1,0,0,            1,32'hFFFF_FFFC,0,0);
    add(1,1,1,0,0,            1,32'h0,  0,0);
    add(1,1,1,0,0,            1,32'h4,  1,32'hFFFF_FFFC);
    add(1,1,1,0,0,            1,32'h8,  1,32'h0);
    add(1,0,1,0,0,            0,32'hC,  1,32'h4);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < tv.size(); i++)
      step(tv[i], i);

    // buffer full, decode stalled: async reset must clear at once
    id_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("full id_valid", 32'(id_valid), 32'd1);
    chk("full id_pc", id_pc, 32'h4);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    mq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    id_ready = 1'b1;
    #1;
    chk("post c0 req_valid", 32'(imem_req_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("post c1 req_valid", 32'(imem_req_valid), 32'd1);
    chk("post c1 req_addr", imem_req_addr, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
